// File: rtl/masked_sbox_pkg.sv
// masked_sbox_pkg: shared constants, share type and GF(2^8) helpers for the masked S-box stream
package masked_sbox_pkg;
  localparam int SHARE_W = 8;
  localparam int CORE_STAGES = 2;
  typedef logic [SHARE_W-1:0] share_t;
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
  function automatic share_t gf_mul(input share_t a, input share_t b);
    share_t p, x;
    p = '0;
    x = a;
    for (int i = 0; i < SHARE_W; i++) begin
      p ^= b[i] ? x : '0;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
endpackage

// File: rtl/masked_sbox_core.sv
// masked_sbox_core: two-stage share-wise AES S-box, inversion as x^254 with ISW multiplications
module masked_sbox_core
  import masked_sbox_pkg::*;
#(
  parameter int NUM_SHARES = 3,
  parameter int RAND_W1 = 278,
  parameter int RAND_W2 = 508
) (
  input  logic                          clk,
  input  logic [SHARE_W*NUM_SHARES-1:0] in_shares,
  input  logic [RAND_W1-1:0]            r1,
  input  logic [RAND_W2-1:0]            r2,
  output logic [SHARE_W*NUM_SHARES-1:0] out_shares
);
  localparam int P = NUM_SHARES * (NUM_SHARES - 1) / 2;
  localparam int RF = 2 * SHARE_W * P;
  typedef share_t [NUM_SHARES-1:0] sv_t;
  function automatic sv_t sq(input sv_t a);
    sv_t c;
    for (int i = 0; i < NUM_SHARES; i++) c[i] = gf_mul(a[i], a[i]);
    return c;
  endfunction
  function automatic sv_t isw(input sv_t a, input sv_t b, input logic [SHARE_W*P-1:0] r);
    sv_t c;
    int k;
    k = 0;
    for (int i = 0; i < NUM_SHARES; i++) c[i] = gf_mul(a[i], b[i]);
    for (int i = 0; i < NUM_SHARES; i++)
      for (int j = i + 1; j < NUM_SHARES; j++) begin
        c[i] ^= r[SHARE_W*k+:SHARE_W];
        c[j] ^= (r[SHARE_W*k+:SHARE_W] ^ gf_mul(a[i], b[j])) ^ gf_mul(a[j], b[i]);
        k++;
      end
    return c;
  endfunction
  function automatic sv_t affine(input sv_t a);
    sv_t c;
    for (int i = 0; i < NUM_SHARES; i++)
      c[i] = a[i] ^ {a[i][6:0], a[i][7]} ^ {a[i][5:0], a[i][7:6]} ^
             {a[i][4:0], a[i][7:5]} ^ {a[i][3:0], a[i][7:4]};
    c[0] ^= 8'h63;
    return c;
  endfunction
  logic [RF-1:0] f1, f2;
  sv_t x, x2, x3, x12, x15, s_x2, s_x12, s_x15, x240, x252, x254, q;
  // fold every supplied random bit into the masks: disjoint XOR bins stay uniform and independent
  always_comb begin
    f1 = '0;
    f2 = '0;
    for (int m = 0; m < RAND_W1; m++) f1[m % RF] ^= r1[m];
    for (int m = 0; m < RAND_W2; m++) f2[m % RF] ^= r2[m];
  end
  always_comb begin
    x    = in_shares;
    x2   = sq(x);
    x3   = isw(x2, x, f1[0+:SHARE_W*P]);
    x12  = sq(sq(x3));
    x15  = isw(x12, x3, f1[SHARE_W*P+:SHARE_W*P]);
    x240 = sq(sq(sq(sq(s_x15))));
    x252 = isw(x240, s_x12, f2[0+:SHARE_W*P]);
    x254 = isw(x252, s_x2, f2[SHARE_W*P+:SHARE_W*P]);
  end
  always_ff @(posedge clk) begin
    s_x2  <= x2;
    s_x12 <= x12;
    s_x15 <= x15;
    q     <= affine(x254);
  end
  assign out_shares = q;
endmodule

// File: rtl/masked_sbox_stream.sv
// masked_sbox_stream: credit-controlled valid/ready wrapper with output FIFO around the masked S-box core
// SBOX_IDLE_ZERO_EN: when defined, core inputs and stage-2 randomness are zeroed in cycles without accept
module masked_sbox_stream
  import masked_sbox_pkg::*;
#(
  parameter int NUM_SHARES = 3,
  parameter int RAND_W1 = 278,
  parameter int RAND_W2 = 508,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SHARE_W*NUM_SHARES-1:0] in_shares,
  input  logic                          rand_valid,
  output logic                          rand_ready,
  input  logic [RAND_W1+RAND_W2-1:0]    rand_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SHARE_W*NUM_SHARES-1:0] out_shares,
  output logic                          busy,
  output logic [CNT_W-1:0]              starve_cnt
);
  localparam int PW = ptr_w(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int NW = SHARE_W * NUM_SHARES;
  logic [CORE_STAGES-1:0] vld;
  logic [CW-1:0] cnt;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [NW-1:0] mem [FIFO_DEPTH];
  logic [NW-1:0] core_in, core_out;
  logic [RAND_W1-1:0] core_r1;
  logic [RAND_W2-1:0] r2, r2_next;
  logic credit, accept, wr, pop;
  assign credit = 32'(cnt) + 32'($countones(vld)) < 32'(FIFO_DEPTH);
  assign in_ready = !rst & rand_valid & credit;
  assign rand_ready = !rst & in_valid & credit;
  assign accept = in_valid & in_ready;
  assign wr = vld[CORE_STAGES-1];
  assign out_valid = cnt != '0;
  assign pop = out_valid & out_ready;
  assign out_shares = out_valid ? mem[rd_ptr] : '0;
  assign busy = |vld | out_valid;
`ifdef SBOX_IDLE_ZERO_EN
  assign core_in = accept ? in_shares : '0;
  assign core_r1 = accept ? rand_data[RAND_W1-1:0] : '0;
  assign r2_next = accept ? rand_data[RAND_W1+:RAND_W2] : '0;
`else
  assign core_in = in_shares;
  assign core_r1 = rand_data[RAND_W1-1:0];
  assign r2_next = rand_data[RAND_W1+:RAND_W2];
`endif
  masked_sbox_core #(
    .NUM_SHARES(NUM_SHARES),
    .RAND_W1(RAND_W1),
    .RAND_W2(RAND_W2)
  ) u_core (
    .clk(clk),
    .in_shares(core_in),
    .r1(core_r1),
    .r2(r2),
    .out_shares(core_out)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      r2 <= '0;
      starve_cnt <= '0;
    end else begin
      vld <= {vld[CORE_STAGES-2:0], accept};
      r2 <= r2_next;
      cnt <= cnt + CW'(wr) - CW'(pop);
      if (wr) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (in_valid & credit & !rand_valid & ~&starve_cnt) starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end
  always_ff @(posedge clk) if (wr) mem[wr_ptr] <= core_out;
endmodule
